sd_dat_rx: RTL and testbench



---
 rtl/sd_dat_rx.sv | 240 ++++++++++++++++++++++++
 tb/tb_sd_dat_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_rx.sv
// SD card read data path: samples 1/4/8 DAT lanes on SD clock rising strobes,
// checks per-lane CRC16 and end bits, and packs bytes big-endian into FIFO words.
module sd_dat_rx #(
    parameter int unsigned LANES            = 4,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BLOCK_SIZE_WIDTH = 10,
    parameter int unsigned TIMEOUT_WIDTH    = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_sd_clk_strobe_rising,
    input  logic [LANES-1:0]            i_dat,
    input  logic [1:0]                  i_width,
    input  logic [BLOCK_SIZE_WIDTH-1:0] i_block_size,
    input  logic [10:0]                 i_num_blocks,
    input  logic                        i_start,
    input  logic                        i_stop,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_crc_error,
    output logic                        o_timeout,
    output logic                        o_clock_stop,
    input  logic                        i_fifo_ready,
    output logic                        o_fifo_push,
    output logic [DATA_WIDTH-1:0]       o_fifo_data
);
    localparam int unsigned BW = BLOCK_SIZE_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_WAIT_START, S_DATA, S_CRC, S_END} state_e;
    typedef enum logic [1:0] {M_1, M_4, M_8} mode_e;

    state_e                   state_q, state_d;
    mode_e                    mode_q, mode_d, mode_sel;
    logic [BW-1:0]            bsize_q, bsize_d, bytes_q, bytes_d, bytes_nxt;
    logic [10:0]              nblk_q, nblk_d, blk_q, blk_d, blk_nxt;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d, tmo_nxt;
    logic [6:0]               wbits_q, wbits_d, wbits_nxt;
    logic [3:0]               crcbit_q, crcbit_d;
    logic [DATA_WIDTH-1:0]    word_q, word_d, fdata_q, fdata_d;
    logic [15:0]              crc_q [LANES];
    logic [15:0]              crc_d [LANES];
    logic                     crc_err_q, crc_err_d, timeout_q, timeout_d;
    logic                     done_q, done_d, push_q, push_d, cstop_q, cstop_d;

    logic [7:0] dat_pad, lane_mask;
    logic [3:0] nbits;
    logic       strobe, start_ok, byte_done, word_done, block_done, crc_last, timeout_hit, last_block;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        dat_pad            = '0;
        dat_pad[LANES-1:0] = i_dat;
    end

    // Widths the instance cannot physically sample fall back to 1-lane.
    always_comb begin
        mode_sel = M_1;
        if (i_width == 2'd1 && LANES >= 4)      mode_sel = M_4;
        else if (i_width == 2'd2 && LANES >= 8) mode_sel = M_8;
    end

    always_comb begin
        lane_mask = 8'h01;
        nbits     = 4'd1;
        unique case (mode_q)
            M_4:     begin lane_mask = 8'h0F; nbits = 4'd4; end
            M_8:     begin lane_mask = 8'hFF; nbits = 4'd8; end
            default: begin lane_mask = 8'h01; nbits = 4'd1; end
        endcase
    end

    assign strobe      = i_sd_clk_strobe_rising;
    assign start_ok    = i_start && !i_stop;
    assign wbits_nxt   = wbits_q + 7'(nbits);
    assign byte_done   = (wbits_nxt[2:0] == 3'd0);
    assign word_done   = (wbits_nxt == 7'(DATA_WIDTH));
    assign bytes_nxt   = bytes_q + BW'(1);
    assign block_done  = byte_done && (bytes_nxt == bsize_q);
    assign crc_last    = (crcbit_q == 4'd15);
    assign tmo_nxt     = tmo_q + TIMEOUT_WIDTH'(1);
    assign timeout_hit = (tmo_nxt == '1);
    assign blk_nxt     = blk_q + 11'd1;
    assign last_block  = (nblk_q != 11'd0) && (blk_nxt == nblk_q);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:       if (start_ok) state_d = S_GAP;
            S_GAP:        if (i_fifo_ready) state_d = S_WAIT_START;
            S_WAIT_START: if (strobe) begin
                              if (!dat_pad[0])     state_d = S_DATA;
                              else if (timeout_hit) state_d = S_IDLE;
                          end
            S_DATA:       if (strobe && block_done) state_d = S_CRC;
            S_CRC:        if (strobe && crc_last) state_d = S_END;
            S_END:        if (strobe) state_d = last_block ? S_IDLE : S_GAP;
            default:      state_d = S_IDLE;
        endcase
        if (i_stop) state_d = S_IDLE;
    end

    always_comb begin
        mode_d    = mode_q;
        bsize_d   = bsize_q;
        nblk_d    = nblk_q;
        bytes_d   = bytes_q;
        blk_d     = blk_q;
        tmo_d     = tmo_q;
        wbits_d   = wbits_q;
        crcbit_d  = crcbit_q;
        word_d    = word_q;
        fdata_d   = fdata_q;
        crc_d     = crc_q;
        crc_err_d = crc_err_q;
        timeout_d = timeout_q;
        cstop_d   = cstop_q;
        done_d    = 1'b0;
        push_d    = 1'b0;
        unique case (state_q)
            S_IDLE: if (start_ok) begin
                mode_d = mode_sel;
                if (i_block_size == '0) begin
                    bsize_d                   = '0;
                    bsize_d[BLOCK_SIZE_WIDTH] = 1'b1;
                end else begin
                    bsize_d = {1'b0, i_block_size};
                end
                nblk_d    = i_num_blocks;
                blk_d     = '0;
                crc_err_d = 1'b0;
                timeout_d = 1'b0;
                cstop_d   = !i_fifo_ready;
            end
            S_GAP: begin
                cstop_d = !i_fifo_ready;
                tmo_d   = '0;
            end
            S_WAIT_START: begin
                for (int unsigned l = 0; l < LANES; l++) crc_d[l] = '0;
                wbits_d  = '0;
                bytes_d  = '0;
                crcbit_d = '0;
                if (strobe && dat_pad[0]) begin
                    tmo_d = tmo_nxt;
                    if (timeout_hit) timeout_d = 1'b1;
                end
            end
            S_DATA: if (strobe) begin
                word_d  = (word_q << nbits) | DATA_WIDTH'(dat_pad & lane_mask);
                wbits_d = word_done ? '0 : wbits_nxt;
                if (byte_done) bytes_d = bytes_nxt;
                if (word_done) begin
                    push_d  = 1'b1;
                    fdata_d = word_d;
                end
                for (int unsigned l = 0; l < LANES; l++)
                    if (lane_mask[l]) crc_d[l] = crc_step(crc_q[l], dat_pad[l]);
            end
            // Received CRC bits are compared against the MSB of the running CRC,
            // which is shifted out one bit per strobe.
            S_CRC: if (strobe) begin
                crcbit_d = crcbit_q + 4'd1;
                for (int unsigned l = 0; l < LANES; l++) begin
                    if (lane_mask[l]) begin
                        if (dat_pad[l] != crc_q[l][15]) crc_err_d = 1'b1;
                        crc_d[l] = {crc_q[l][14:0], 1'b0};
                    end
                end
            end
            S_END: if (strobe) begin
                if ((dat_pad & lane_mask) != lane_mask) crc_err_d = 1'b1;
                blk_d = blk_nxt;
                if (last_block) done_d = 1'b1;
                else            cstop_d = !i_fifo_ready;
            end
            default: ;
        endcase
        if (i_stop) begin
            push_d  = 1'b0;
            done_d  = 1'b0;
            cstop_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mode_q    <= M_1;
            bsize_q   <= '0;
            nblk_q    <= '0;
            bytes_q   <= '0;
            blk_q     <= '0;
            tmo_q     <= '0;
            wbits_q   <= '0;
            crcbit_q  <= '0;
            word_q    <= '0;
            fdata_q   <= '0;
            for (int unsigned l = 0; l < LANES; l++) crc_q[l] <= '0;
            crc_err_q <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            push_q    <= 1'b0;
            cstop_q   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            bsize_q   <= bsize_d;
            nblk_q    <= nblk_d;
            bytes_q   <= bytes_d;
            blk_q     <= blk_d;
            tmo_q     <= tmo_d;
            wbits_q   <= wbits_d;
            crcbit_q  <= crcbit_d;
            word_q    <= word_d;
            fdata_q   <= fdata_d;
            crc_q     <= crc_d;
            crc_err_q <= crc_err_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            push_q    <= push_d;
            cstop_q   <= cstop_d;
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = done_q;
    assign o_crc_error  = crc_err_q;
    assign o_timeout    = timeout_q;
    assign o_clock_stop = cstop_q;
    assign o_fifo_push  = push_q;
    assign o_fifo_data  = fdata_q;
endmodule

// File: tb/tb_sd_dat_rx.sv
// Scoreboard bench for sd_dat_rx: a card model drives DAT lanes, expected FIFO
// words are queued up front and a negedge monitor checks each push.
module tb_sd_dat_rx;
    logic        clk = 1'b0;
    logic        rst, stb, start, stop, ready;
    logic [7:0]  dat;
    logic [1:0]  width;
    logic [9:0]  bsize;
    logic [10:0] nblk;
    logic        busy, done, err, tmo, cstop, push;
    logic [31:0] fdata;

    logic [31:0] exp_q[$];
    logic [7:0]  blk[$];
    int          tests = 0, failed = 0, done_cnt = 0, d0;

    always #5 clk = ~clk;

    sd_dat_rx #(
        .LANES(8), .DATA_WIDTH(32), .BLOCK_SIZE_WIDTH(10), .TIMEOUT_WIDTH(4)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_sd_clk_strobe_rising(stb), .i_dat(dat),
        .i_width(width), .i_block_size(bsize), .i_num_blocks(nblk),
        .i_start(start), .i_stop(stop), .o_busy(busy), .o_done(done),
        .o_crc_error(err), .o_timeout(tmo), .o_clock_stop(cstop),
        .i_fifo_ready(ready), .o_fifo_push(push), .o_fifo_data(fdata)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (push) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL push: unexpected word %08h, required no push", fdata);
            end else begin
                logic [31:0] w;
                w = exp_q.pop_front();
                if (fdata !== w) begin
                    failed++;
                    $display("FAIL push_data: got %08h, required %08h", fdata, w);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic strobe(input logic [7:0] d);
        dat = d;
        stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [16:0] div_step(input logic [16:0] r, input logic b);
        logic [16:0] t;
        t = {r[15:0], b};
        if (t[16]) t = t ^ 17'h11021;
        return t;
    endfunction

    task automatic fill_inc(input int first, input int count);
        blk.delete();
        for (int i = 0; i < count; i++) blk.push_back(8'(first + i));
    endtask

    task automatic exp_blk();
        for (int i = 0; i < blk.size(); i += 4)
            exp_q.push_back({blk[i], blk[i+1], blk[i+2], blk[i+3]});
    endtask

    task automatic start_xfer(input logic [1:0] w, input logic [9:0] bs, input logic [10:0] nb);
        width = w;
        bsize = bs;
        nblk  = nb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("busy_after_start", busy, 1);
    endtask

    // Card model: idle, start bit, data, per-lane CRC16 (remainder by long division), end bit.
    task automatic send_block(input int n, input int bad_lane, input bit fixed_en,
                              input logic [15:0] fixed_crc, input bit bad_end, input bit tail);
        logic [16:0] rem [8];
        logic [15:0] crc [8];
        logic [7:0]  d, b;
        for (int l = 0; l < 8; l++) rem[l] = '0;
        strobe(8'hFF);
        strobe(8'hFF);
        strobe(8'h00);
        foreach (blk[i]) begin
            b = blk[i];
            for (int s = 0; s < 8 / n; s++) begin
                d = 8'hFF;
                for (int l = 0; l < n; l++) begin
                    d[l]   = b[8 - n * (s + 1) + l];
                    rem[l] = div_step(rem[l], d[l]);
                end
                strobe(d);
            end
        end
        if (!tail) return;
        for (int l = 0; l < 8; l++) begin
            for (int k = 0; k < 16; k++) rem[l] = div_step(rem[l], 1'b0);
            crc[l] = rem[l][15:0];
        end
        if (fixed_en) crc[0] = fixed_crc;
        if (bad_lane >= 0) crc[bad_lane] = crc[bad_lane] ^ 16'h8000;
        for (int i = 0; i < 16; i++) begin
            d = 8'hFF;
            for (int l = 0; l < n; l++) d[l] = crc[l][15 - i];
            strobe(d);
        end
        d = 8'hFF;
        if (bad_end) d[0] = 1'b0;
        strobe(d);
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b1;
        dat = 8'hFF; width = 2'd0; bsize = 10'd8; nblk = 11'd1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_outputs", {26'd0, busy, done, err, tmo, cstop, push}, 0);
        @(posedge clk); #1;

        // 1-lane, 8 bytes 0x01..0x08
        fill_inc(1, 8);
        exp_q.push_back(32'h01020304);
        exp_q.push_back(32'h05060708);
        d0 = done_cnt;
        start_xfer(2'd0, 10'd8, 11'd1);
        send_block(1, -1, 0, 16'h0, 0, 1);
        check("t1_done", done_cnt - d0, 1);
        check("t1_crc_err", err, 0);
        check("t1_busy_low", busy, 0);
        check("t1_all_words", exp_q.size(), 0);

        // bad end bit
        fill_inc(1, 8);
        exp_blk();
        d0 = done_cnt;
        start_xfer(2'd0, 10'd8, 11'd1);
        send_block(1, -1, 0, 16'h0, 1, 1);
        check("endbit_err", err, 1);
        check("endbit_done", done_cnt - d0, 1);

        // 512 bytes of 0xFF with the known card CRC, then with it off by one
        for (int pass = 0; pass < 2; pass++) begin
            blk.delete();
            for (int i = 0; i < 512; i++) blk.push_back(8'hFF);
            exp_blk();
            d0 = done_cnt;
            start_xfer(2'd0, 10'd512, 11'd1);
            send_block(1, -1, 1, (pass == 0) ? 16'h7FA1 : 16'h7FA0, 0, 1);
            check("t2_crc_err", err, (pass == 0) ? 0 : 1);
            check("t2_done", done_cnt - d0, 1);
            check("t2_all_words", exp_q.size(), 0);
        end

        // 4-lane and 8-lane, two 16-byte blocks, clean then DAT2 CRC corrupt in block 2
        for (int m = 0; m < 2; m++) begin
            for (int bad = 0; bad < 2; bad++) begin
                d0 = done_cnt;
                start_xfer((m == 0) ? 2'd1 : 2'd2, 10'd16, 11'd2);
                fill_inc(0, 16);
                exp_blk();
                send_block((m == 0) ? 4 : 8, -1, 0, 16'h0, 0, 1);
                check("t3_err_blk1", err, 0);
                check("t3_busy_blk1", busy, 1);
                fill_inc(16, 16);
                exp_blk();
                send_block((m == 0) ? 4 : 8, (bad == 1) ? 2 : -1, 0, 16'h0, 0, 1);
                check("t3_err_blk2", err, bad);
                check("t3_done", done_cnt - d0, 1);
                check("t3_all_words", exp_q.size(), 0);
            end
        end

        // start-bit timeout with TIMEOUT_WIDTH=4
        d0 = done_cnt;
        start_xfer(2'd0, 10'd8, 11'd1);
        repeat (14) strobe(8'hFF);
        check("tmo_before", {30'd0, tmo, busy}, 32'h1);
        strobe(8'hFF);
        check("tmo_flag", tmo, 1);
        check("tmo_busy", busy, 0);
        check("tmo_no_done", done_cnt - d0, 0);

        // FIFO backpressure between blocks of a 3-block read
        d0 = done_cnt;
        start_xfer(2'd1, 10'd8, 11'd3);
        check("tmo_cleared", tmo, 0);
        ready = 1'b0;
        fill_inc(8'h40, 8);
        exp_blk();
        send_block(4, -1, 0, 16'h0, 0, 1);
        check("cstop_set", cstop, 1);
        repeat (3) strobe(8'h00);
        check("cstop_hold", {30'd0, cstop, busy}, 32'h3);
        ready = 1'b1;
        @(posedge clk); #1;
        check("cstop_clear", cstop, 0);
        fill_inc(8'h48, 8);
        exp_blk();
        send_block(4, -1, 0, 16'h0, 0, 1);
        fill_inc(8'h50, 8);
        exp_blk();
        send_block(4, -1, 0, 16'h0, 0, 1);
        check("cs_done", done_cnt - d0, 1);
        check("cs_err", err, 0);
        check("cs_all_words", exp_q.size(), 0);

        // unlimited blocks, stop mid block 6 with a partial word pending
        d0 = done_cnt;
        start_xfer(2'd1, 10'd8, 11'd0);
        for (int b = 0; b < 5; b++) begin
            fill_inc(b * 8, 8);
            exp_blk();
            send_block(4, -1, 0, 16'h0, 0, 1);
        end
        check("unl_no_done", done_cnt - d0, 0);
        check("unl_busy", busy, 1);
        fill_inc(8'hA0, 6);
        exp_q.push_back(32'hA0A1A2A3);
        send_block(4, -1, 0, 16'h0, 0, 0);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_cstop", cstop, 0);
        repeat (4) @(posedge clk);
        #1;
        check("stop_no_done", done_cnt - d0, 0);
        check("stop_words", exp_q.size(), 0);

        // restart after stop
        d0 = done_cnt;
        start_xfer(2'd1, 10'd8, 11'd1);
        fill_inc(8'h10, 8);
        exp_blk();
        send_block(4, -1, 0, 16'h0, 0, 1);
        check("restart_done", done_cnt - d0, 1);
        check("restart_err", err, 0);
        check("restart_words", exp_q.size(), 0);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
